// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore control FSM sequencing the multicycle RV32I datapath
// (one shared memory, one shared ALU) for lw, sw, R-type, I-type, jal and beq.
// Optional feature macro: MULTICYCLE_BNE_EN -- when defined, BRANCH also resolves
// bne (funct3=001); when undefined, any branch other than beq is decoded as illegal.
module multicycle_controller (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       EN,
  input  logic [6:0] OP,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  state_t     state_q, state_d;
  logic [1:0] alu_op;
  logic       pc_update, branch, ir_write, reg_write, mem_write;
  logic       illegal_op, taken, we_ok;

  // State register: reset wins over the stall enable
  always_ff @(posedge CLK) begin
    if (RESET)   state_q <= S_FETCH;
    else if (EN) state_q <= state_d;
  end

  // Opcode legality as seen in DECODE
  always_comb begin
    illegal_op = 1'b1;
    case (OP)
      OP_LW, OP_SW, OP_R, OP_I, OP_JAL: illegal_op = 1'b0;
`ifdef MULTICYCLE_BNE_EN
      OP_BR:                            illegal_op = 1'b0;
`else
      OP_BR:                            illegal_op = (funct3 != 3'b000);
`endif
      default:                          illegal_op = 1'b1;
    endcase
  end

  // Branch outcome from the ALU zero flag
  always_comb begin
`ifdef MULTICYCLE_BNE_EN
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = ~Zero;
      default: taken = 1'b0;
    endcase
`else
    taken = Zero;
`endif
  end

  // Next-state logic and Moore per-state outputs
  always_comb begin
    state_d   = S_FETCH;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = 2'b00;
    pc_update = 1'b0;
    branch    = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write  = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_update = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        if (illegal_op)                     state_d = S_FETCH;
        else if (OP == OP_LW || OP == OP_SW) state_d = S_MEMADR;
        else if (OP == OP_R)                state_d = S_EXECR;
        else if (OP == OP_I)                state_d = S_EXECI;
        else if (OP == OP_JAL)              state_d = S_JAL;
        else                                state_d = S_BRANCH;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = OP[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
        state_d = S_ALUWB;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // ALU operation decode from ALUOp and the instruction fields
  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (OP[5] & funct7) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  // Immediate format, a function of the opcode alone
  always_comb begin
    ImmSrc = 2'b00;
    case (OP)
      OP_SW:   ImmSrc = 2'b01;
      OP_BR:   ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Write enables are suppressed while stalled or held in reset
  assign we_ok    = EN & ~RESET;
  assign PCWrite  = we_ok & (pc_update | (branch & taken));
  assign IRWrite  = we_ok & ir_write;
  assign RegWrite = we_ok & reg_write;
  assign MemWrite = we_ok & mem_write;
  assign Illegal  = we_ok & (state_q == S_DECODE) & illegal_op;
  assign State    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: decode table, hand-written corner
// sequences (reset, stall, illegal, branch) and a randomized instruction stream
// checked against per-instruction step lists.
module tb_multicycle_controller;

  logic       CLK = 1'b0;
  logic       RESET, EN, funct7, Zero;
  logic [6:0] OP;
  logic [2:0] funct3;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  multicycle_controller dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .OP(OP), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Illegal(Illegal),
    .State(State)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    OP = op; funct3 = f3; funct7 = f7;
  endtask

  task automatic do_reset();
    RESET = 1'b1; EN = 1'b1;
    cyc(); cyc();
    RESET = 1'b0;
  endtask

  // Reference: the state visited on each enabled cycle of one instruction
  int exp_seq[6];
  int exp_len;

  task automatic build_seq(input logic [6:0] op, input logic [2:0] f3);
    exp_seq = '{0, 1, 0, 0, 0, 0};
    case (op)
      7'b0000011: begin exp_seq[2] = 2; exp_seq[3] = 3; exp_seq[4] = 4; exp_len = 5; end
      7'b0100011: begin exp_seq[2] = 2; exp_seq[3] = 5; exp_len = 4; end
      7'b0110011: begin exp_seq[2] = 6; exp_seq[3] = 7; exp_len = 4; end
      7'b0010011: begin exp_seq[2] = 8; exp_seq[3] = 7; exp_len = 4; end
      7'b1101111: begin exp_seq[2] = 9; exp_seq[3] = 7; exp_len = 4; end
`ifdef MULTICYCLE_BNE_EN
      7'b1100011: begin exp_seq[2] = 10; exp_len = 3; end
`else
      7'b1100011: begin
        if (f3 == 3'b000) begin exp_seq[2] = 10; exp_len = 3; end
        else exp_len = 2;
      end
`endif
      default: exp_len = 2;
    endcase
  endtask

  function automatic logic branch_taken(input logic [2:0] f3, input logic z);
`ifdef MULTICYCLE_BNE_EN
    return (f3 == 3'b000) ? z : (f3 == 3'b001) ? ~z : 1'b0;
`else
    return (f3 == 3'b000) ? z : 1'b0;
`endif
  endfunction

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       chk_imm;
    logic [1:0] imm;
    logic [2:0] alu3;  // ALUControl in the cycle after DECODE
    int         cpi;
  } vec_t;

  vec_t tbl[14];
  logic [6:0] opc[8];

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt, rw_pulses, idx, guard, st;
    logic tk;

    tbl[0]  = '{7'b0000011, 3'b010, 1'b0, 1'b1, 2'b00, 3'b000, 5};
    tbl[1]  = '{7'b0100011, 3'b010, 1'b0, 1'b1, 2'b01, 3'b000, 4};
    tbl[2]  = '{7'b0110011, 3'b000, 1'b0, 1'b0, 2'b00, 3'b000, 4};
    tbl[3]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 2'b00, 3'b001, 4};
    tbl[4]  = '{7'b0110011, 3'b010, 1'b0, 1'b0, 2'b00, 3'b101, 4};
    tbl[5]  = '{7'b0110011, 3'b110, 1'b0, 1'b0, 2'b00, 3'b011, 4};
    tbl[6]  = '{7'b0110011, 3'b111, 1'b0, 1'b0, 2'b00, 3'b010, 4};
    tbl[7]  = '{7'b0010011, 3'b000, 1'b1, 1'b1, 2'b00, 3'b000, 4};
    tbl[8]  = '{7'b0010011, 3'b010, 1'b0, 1'b1, 2'b00, 3'b101, 4};
    tbl[9]  = '{7'b0110011, 3'b100, 1'b0, 1'b0, 2'b00, 3'b000, 4};
    tbl[10] = '{7'b1101111, 3'b000, 1'b0, 1'b1, 2'b11, 3'b000, 4};
    tbl[11] = '{7'b1100011, 3'b000, 1'b0, 1'b1, 2'b10, 3'b001, 3};
    tbl[12] = '{7'b1111111, 3'b000, 1'b0, 1'b0, 2'b00, 3'b000, 2};
`ifdef MULTICYCLE_BNE_EN
    tbl[13] = '{7'b1100011, 3'b001, 1'b0, 1'b1, 2'b10, 3'b001, 3};
`else
    tbl[13] = '{7'b1100011, 3'b001, 1'b0, 1'b1, 2'b10, 3'b000, 2};
`endif
    opc = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
            7'b1101111, 7'b1100011, 7'b1111111, 7'b0010111};

    RESET = 1'b1; EN = 1'b0; Zero = 1'b0;
    set_instr(7'b0110011, 3'b000, 1'b0);
    cyc(); cyc();
    chk("rst_hold_pcwrite", PCWrite, 1'b0);
    chk("rst_hold_irwrite", IRWrite, 1'b0);
    EN = 1'b1;
    RESET = 1'b0;

    // Reset held 2 cycles from ALUWB
    cyc(); cyc(); cyc();
    chk("r_reach_aluwb", State, 4'd7);
    RESET = 1'b1;
    #1 chk("rst_regwrite_forced", RegWrite, 1'b0);
    cyc(); cyc();
    RESET = 1'b0;
    #1;
    chk("rst_state", State, 4'd0);
    chk("rst_pcwrite", PCWrite, 1'b1);
    chk("rst_irwrite", IRWrite, 1'b1);
    chk("rst_regwrite", RegWrite, 1'b0);
    chk("rst_memwrite", MemWrite, 1'b0);

    // lw walk
    set_instr(7'b0000011, 3'b010, 1'b0);
    build_seq(OP, funct3);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("lw_state%0d", i), State, exp_seq[i]);
      chk($sformatf("lw_regwrite%0d", i), RegWrite, exp_seq[i] == 4);
      chk($sformatf("lw_adrsrc%0d", i), AdrSrc, exp_seq[i] == 3);
      chk($sformatf("lw_immsrc%0d", i), ImmSrc, 2'b00);
      cyc();
    end
    chk("lw_back_fetch", State, 4'd0);

    // sw then sub
    set_instr(7'b0100011, 3'b010, 1'b0);
    build_seq(OP, funct3);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("sw_state%0d", i), State, exp_seq[i]);
      chk($sformatf("sw_memwrite%0d", i), MemWrite, exp_seq[i] == 5);
      chk($sformatf("sw_immsrc%0d", i), ImmSrc, 2'b01);
      cyc();
    end
    set_instr(7'b0110011, 3'b000, 1'b1);
    cyc(); cyc();
    chk("sub_state6", State, 4'd6);
    chk("sub_aluctl", ALUControl, 3'b001);
    cyc();
    chk("sub_state7", State, 4'd7);
    chk("sub_regwrite", RegWrite, 1'b1);
    cyc();

    // beq taken / not taken
    for (int z = 1; z >= 0; z--) begin
      set_instr(7'b1100011, 3'b000, 1'b0);
      Zero = z[0];
      chk($sformatf("beq%0d_s0", z), State, 4'd0);
      cyc();
      chk($sformatf("beq%0d_s1", z), State, 4'd1);
      cyc();
      chk($sformatf("beq%0d_s10", z), State, 4'd10);
      chk($sformatf("beq%0d_pcwrite", z), PCWrite, z[0]);
      cyc();
      chk($sformatf("beq%0d_end", z), State, 4'd0);
    end
`ifdef MULTICYCLE_BNE_EN
    set_instr(7'b1100011, 3'b001, 1'b0);
    Zero = 1'b0;
    cyc(); cyc();
    chk("bne_state", State, 4'd10);
    chk("bne_pcwrite", PCWrite, 1'b1);
    cyc();
`endif

    // Stall in MEMREAD
    set_instr(7'b0000011, 3'b010, 1'b0);
    cyc(); cyc(); cyc();
    chk("stall_enter", State, 4'd3);
    rw_pulses = 0;
    EN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall_state%0d", i), State, 4'd3);
      chk($sformatf("stall_we%0d", i), {PCWrite, IRWrite, RegWrite, MemWrite}, 4'b0000);
      chk($sformatf("stall_adrsrc%0d", i), AdrSrc, 1'b1);
      cyc();
    end
    EN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (RegWrite) rw_pulses++;
      if (i == 1) chk("stall_resume_s4", State, 4'd4);
      cyc();
    end
    chk("stall_single_regwrite", rw_pulses, 1);
    chk("stall_end_s1", State, 4'd1);
    do_reset();

    // Illegal opcode
    set_instr(7'b1111111, 3'b000, 1'b0);
    #1 chk("ill_fetch", Illegal, 1'b0);
    cyc();
    chk("ill_state1", State, 4'd1);
    chk("ill_pulse", Illegal, 1'b1);
    cyc();
    chk("ill_back", State, 4'd0);
    chk("ill_clear", Illegal, 1'b0);

    // Reset while in MEMWRITE
    set_instr(7'b0100011, 3'b010, 1'b0);
    cyc(); cyc(); cyc();
    chk("rmid_state5", State, 4'd5);
    RESET = 1'b1;
    #1 chk("rmid_memwrite", MemWrite, 1'b0);
    cyc();
    RESET = 1'b0;
    #1 chk("rmid_next", State, 4'd0);

    // Decode table: ImmSrc, ALUControl after DECODE, cycles per instruction
    for (int i = 0; i < 14; i++) begin
      set_instr(tbl[i].op, tbl[i].f3, tbl[i].f7);
      Zero = 1'b0;
      #1 chk($sformatf("tbl%0d_start", i), State, 4'd0);
      cyc();
      if (tbl[i].chk_imm) chk($sformatf("tbl%0d_imm", i), ImmSrc, tbl[i].imm);
      cyc();
      chk($sformatf("tbl%0d_alu", i), ALUControl, tbl[i].alu3);
      cnt = 2;
      while (State != 4'd0 && cnt < 12) begin
        cyc();
        cnt++;
      end
      chk($sformatf("tbl%0d_cpi", i), cnt, tbl[i].cpi);
    end

    // Randomized instruction stream with random stalls and Zero
    do_reset();
    for (int n = 0; n < 150; n++) begin
      set_instr(opc[$urandom_range(0, 7)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      build_seq(OP, funct3);
      idx = 0;
      guard = 0;
      while (idx < exp_len && guard < 60) begin
        EN = ($urandom_range(0, 3) != 0);
        Zero = 1'($urandom_range(0, 1));
        #1;
        st = exp_seq[idx];
        tk = (st == 10) && branch_taken(funct3, Zero);
        chk("rnd_state", State, st);
        chk("rnd_regwrite", RegWrite, EN && (st == 4 || st == 7));
        chk("rnd_memwrite", MemWrite, EN && st == 5);
        chk("rnd_irwrite", IRWrite, EN && st == 0);
        chk("rnd_pcwrite", PCWrite, EN && (st == 0 || st == 9 || tk));
        chk("rnd_illegal", Illegal, EN && st == 1 && exp_len == 2);
        cyc();
        if (EN) idx++;
        guard++;
      end
      chk("rnd_done", idx, exp_len);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore-style control FSM that sequences the multicycle variant of our RV32I datapath, which shares one memory and one ALU across fetch, address, and execute steps. It decodes `OP`, `funct3`, and `funct7` (instruction bit 30). It produces per-cycle mux selects, write enables, and `ALUControl`, and it uses `Zero` to resolve branches. It supports lw, sw, R-type ALU, I-type ALU, jal, and beq.

## Interface
- No parameters.
- `CLK`  in  1  system clock; all state updates on rising edge
- `RESET`  in  1  synchronous, active-high; one clock, synchronous active-high reset
- `EN`  in  1  advance enable; low = stall
- `OP`  in  7  Instr[6:0]
- `funct3`  in  3  Instr[14:12]
- `funct7`  in  1  Instr[30]
- `Zero`  in  1  ALU zero flag
- `PCWrite`  out  1  PC register load
- `AdrSrc`  out  1  memory address: 0 = PC, 1 = ALUOut
- `MemWrite`  out  1  data memory write
- `IRWrite`  out  1  instruction/OldPC register load
- `RegWrite`  out  1  register file write
- `ResultSrc`  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- `ALUSrcA`  out  2  00 = PC, 01 = OldPC, 10 = rs1 reg
- `ALUSrcB`  out  2  00 = rs2 reg, 01 = ImmExt, 10 = const 4
- `ImmSrc`  out  2  00 = I, 01 = S, 10 = B, 11 = J; decoded from `OP` only
- `ALUControl`  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- `Illegal`  out  1  one-cycle pulse in DECODE on an unsupported opcode
- `State`  out  4  current state encoding, for debug

## Operation
States and encodings, with asserted outputs (unlisted outputs are 0/00):
- FETCH(0): AdrSrc=0, IRWrite, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate. Next: DECODE.
- DECODE(1): ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next by `OP`:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1101111 → JAL
  - 1100011 → BRANCH
  - any other opcode → FETCH, with `Illegal`=1
- MEMADR(2): ALUSrcA=10, ALUSrcB=01. Next: MEMREAD if OP[5]=0, else MEMWRITE.
- MEMREAD(3): AdrSrc=1, ResultSrc=00. Next: MEMWB.
- MEMWB(4): ResultSrc=01, RegWrite. Next: FETCH.
- MEMWRITE(5): AdrSrc=1, MemWrite. Next: FETCH.
- EXECR(6): ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
- ALUWB(7): ResultSrc=00, RegWrite. Next: FETCH.
- EXECI(8): ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
- JAL(9): ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCUpdate. Next: ALUWB.
- BRANCH(10): ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch. Next: FETCH.
- Encodings 11–15 are unreachable; if entered, next state is FETCH.

Derived signals:
- PCWrite = PCUpdate | (Branch & taken).
- Without the configuration macro, taken = Zero.

ALU decode (combinational):
- ALUOp 00 → add.
- ALUOp 01 → sub.
- ALUOp 10, by funct3:
  - 000 → sub if OP[5] & funct7, else add
  - 010 → slt
  - 110 → or
  - 111 → and
  - other → add

## Timing
- Outputs are a function of the registered state only, except `ImmSrc`, `ALUControl`, and `Illegal`, which are decoded from the current inputs.
- Cycles per instruction, with EN held high: lw 5; sw 4; R-type 4; I-type 4; jal 4; beq 3; illegal 2.
- EN=0:
  - state holds
  - PCWrite, IRWrite, RegWrite, MemWrite, and Illegal are forced to 0
  - selects keep their current-state values
- When EN returns high, the sequence resumes in the held state with no lost or duplicated step.
- RESET=1 at a rising edge: state becomes FETCH, regardless of EN or the current state (including mid-instruction).
- While RESET=1, all write enables and `Illegal` are forced to 0.
- First cycle after reset release: FETCH outputs, with PCWrite=1 and IRWrite=1.
- RESET takes priority over EN.

## Configuration
- `MULTICYCLE_BNE_EN` defined: in BRANCH, the outcome depends on funct3:
  - 000 → taken = Zero
  - 001 → taken = ~Zero
  - other → taken = 0
- `MULTICYCLE_BNE_EN` undefined: in DECODE, opcode 1100011 with funct3 ≠ 000 is illegal. It goes to FETCH with `Illegal`=1 and never enters BRANCH.

## Test plan
- Reset: hold RESET 2 cycles from state 7, then release → State=0, PCWrite=1, IRWrite=1, RegWrite=0, MemWrite=0.
- lw (OP=0000011), EN=1 → State sequence 0,1,2,3,4,0. RegWrite=1 only in state 4; AdrSrc=1 in state 3; ImmSrc=00.
- sw, then R-type sub (OP=0110011, funct3=000, funct7=1):
  - sw: MemWrite=1 only in state 5, ImmSrc=01.
  - sub: ALUControl=001 in state 6, RegWrite in state 7.
- beq with Zero=1, then Zero=0:
  - State sequence 0,1,10,0 in both cases.
  - PCWrite=1 in state 10 only when Zero=1.
  - With the macro defined: bne (funct3=001) with Zero=0 → PCWrite=1.
- Stall: lw, with EN=0 for 3 cycles entering state 3 → State holds at 3, all write enables 0, then resumes 3→4 with a single RegWrite pulse.
- Illegal: OP=1111111 → Illegal=1 for exactly one cycle in state 1, then State=0.
- Reset mid-instruction: assert RESET in state 5 → no MemWrite pulse, next State=0.
